// File: rtl/pi_capture_pkg.sv
// Shared types for the Pi line capture block: line width default, bank and writer states.
package pi_capture_pkg;

  localparam int unsigned LINE_WIDTH_DEFAULT = 720;
  localparam int unsigned X_W = 10;

  typedef enum logic [1:0] {
    BankEmpty,
    BankFilling,
    BankFull
  } bank_state_e;

  typedef enum logic [1:0] {
    WIdle,
    WFill,
    WDrop
  } wr_state_e;

endpackage

// File: rtl/pi_line_ram.sv
// Simple dual-port line RAM, two banks addressed as {bank, x}, registered read port.
module pi_line_ram #(
  parameter int unsigned DATA_W = 24,
  parameter int unsigned AW     = 11
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              we_i,
  input  logic [AW-1:0]     wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic [AW-1:0]     rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o
);

  localparam int unsigned Depth = 2 ** AW;

  logic [DATA_W-1:0] mem_q [Depth];
  logic [DATA_W-1:0] rd_data_q;

  // Array kept free of reset so it maps onto block RAM.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[wr_addr_i] <= wr_data_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) rd_data_q <= '0;
    else         rd_data_q <= mem_q[rd_addr_i];
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/pi_line_capture.sv
// Ping-pong capture of active Pi DPI lines; complete lines are handed to a consumer in order.
module pi_line_capture
  import pi_capture_pkg::*;
#(
  parameter int unsigned LINE_WIDTH = LINE_WIDTH_DEFAULT,
  parameter int unsigned DATA_W     = 24
) (
  input  logic              clk,
  input  logic              nReset,
  input  logic              pixel_ce,
  input  logic [9:0]        pixel_x,
  input  logic [9:0]        pixel_y,
  input  logic [DATA_W-1:0] pixel_data,
  output logic              line_valid,
  output logic [9:0]        line_y,
  input  logic [9:0]        rd_addr,
  output logic [DATA_W-1:0] rd_data,
  input  logic              line_release,
  output logic              overflow,
  output logic              short_line,
  output logic [15:0]       drop_count
);

  localparam logic [9:0] LastX = 10'(LINE_WIDTH - 1);
  localparam logic [9:0] Width = 10'(LINE_WIDTH);

  bank_state_e bank_st_q [2];
  bank_state_e bank_st_d [2];
  logic [9:0]  bank_y_q  [2];
  logic [9:0]  bank_y_d  [2];
  logic        wr_bank_q, wr_bank_d;
  logic        rd_bank_q, rd_bank_d;
  wr_state_e   wst_q, wst_d;
  logic        overflow_q, overflow_d;
  logic        short_q, short_d;
  logic [15:0] drop_q, drop_d;
  logic        release_ok, wr_free, ram_we;

  always_comb begin
    bank_st_d  = bank_st_q;
    bank_y_d   = bank_y_q;
    wr_bank_d  = wr_bank_q;
    rd_bank_d  = rd_bank_q;
    wst_d      = wst_q;
    overflow_d = overflow_q;
    short_d    = short_q;
    drop_d     = drop_q;
    ram_we     = 1'b0;

    release_ok = line_release && (bank_st_q[rd_bank_q] == BankFull);
    // A bank released on this very edge is free for a new line.
    wr_free    = (bank_st_q[wr_bank_q] == BankEmpty) || (release_ok && (rd_bank_q == wr_bank_q));

    if (release_ok) begin
      bank_st_d[rd_bank_q] = BankEmpty;
      rd_bank_d            = ~rd_bank_q;
    end

    if (pixel_ce && (pixel_x < Width)) begin
      case (wst_q)
        WFill: begin
          ram_we = 1'b1;
          if (pixel_x == '0) begin
            bank_y_d[wr_bank_q] = pixel_y;
            short_d             = 1'b1;
          end else if (pixel_x == LastX) begin
            bank_st_d[wr_bank_q] = BankFull;
            wr_bank_d            = ~wr_bank_q;
            wst_d                = WIdle;
          end
        end
        default: begin
          if (pixel_x == '0) begin
            if (wr_free) begin
              ram_we               = 1'b1;
              bank_st_d[wr_bank_q] = BankFilling;
              bank_y_d[wr_bank_q]  = pixel_y;
              wst_d                = WFill;
            end else begin
              wst_d      = WDrop;
              overflow_d = 1'b1;
              if (drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
            end
          end else if ((wst_q == WDrop) && (pixel_x == LastX)) begin
            wst_d = WIdle;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      bank_st_q[0] <= BankEmpty;
      bank_st_q[1] <= BankEmpty;
      bank_y_q[0]  <= '0;
      bank_y_q[1]  <= '0;
      wr_bank_q    <= 1'b0;
      rd_bank_q    <= 1'b0;
      wst_q        <= WIdle;
      overflow_q   <= 1'b0;
      short_q      <= 1'b0;
      drop_q       <= '0;
    end else begin
      bank_st_q  <= bank_st_d;
      bank_y_q   <= bank_y_d;
      wr_bank_q  <= wr_bank_d;
      rd_bank_q  <= rd_bank_d;
      wst_q      <= wst_d;
      overflow_q <= overflow_d;
      short_q    <= short_d;
      drop_q     <= drop_d;
    end
  end

  pi_line_ram #(
    .DATA_W(DATA_W),
    .AW    (X_W + 1)
  ) u_ram (
    .clk_i    (clk),
    .rst_ni   (nReset),
    .we_i     (ram_we),
    .wr_addr_i({wr_bank_q, pixel_x}),
    .wr_data_i(pixel_data),
    .rd_addr_i({rd_bank_q, rd_addr}),
    .rd_data_o(rd_data)
  );

  assign line_valid = (bank_st_q[rd_bank_q] == BankFull);
  assign line_y     = bank_y_q[rd_bank_q];
  assign overflow   = overflow_q;
  assign short_line = short_q;
  assign drop_count = drop_q;

endmodule

// File: tb/tb_pi_line_capture.sv
// Directed bench for pi_line_capture: capture, ping-pong, overflow, short line, reset, edge cases.
module tb_pi_line_capture;

  localparam int LW = 720;
  localparam int DW = 24;

  logic          clk = 1'b0;
  logic          nReset;
  logic          pixel_ce;
  logic [9:0]    pixel_x;
  logic [9:0]    pixel_y;
  logic [DW-1:0] pixel_data;
  logic          line_valid;
  logic [9:0]    line_y;
  logic [9:0]    rd_addr;
  logic [DW-1:0] rd_data;
  logic          line_release;
  logic          overflow;
  logic          short_line;
  logic [15:0]   drop_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pi_line_capture #(
    .LINE_WIDTH(LW),
    .DATA_W    (DW)
  ) dut (
    .clk         (clk),
    .nReset      (nReset),
    .pixel_ce    (pixel_ce),
    .pixel_x     (pixel_x),
    .pixel_y     (pixel_y),
    .pixel_data  (pixel_data),
    .line_valid  (line_valid),
    .line_y      (line_y),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .line_release(line_release),
    .overflow    (overflow),
    .short_line  (short_line),
    .drop_count  (drop_count)
  );

  typedef struct {
    logic [9:0]    addr;
    logic [DW-1:0] exp;
  } rd_vec_t;

  rd_vec_t vec [3];

  // Pixel data encodes its own line and column: {4'b0, y, x}.
  function automatic logic [DW-1:0] pix(input int y, input int x);
    return DW'((y << 10) | x);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One strobe per 8 clk; returns at the negedge just after the strobe's capturing edge.
  task automatic strobe(input int x, input int y, input bit rel);
    repeat (7) @(negedge clk);
    pixel_ce     = 1'b1;
    pixel_x      = 10'(x);
    pixel_y      = 10'(y);
    pixel_data   = pix(y, x);
    line_release = rel;
    @(negedge clk);
    pixel_ce     = 1'b0;
    line_release = 1'b0;
  endtask

  task automatic send_range(input int x0, input int x1, input int y);
    for (int x = x0; x <= x1; x++) strobe(x, y, 1'b0);
  endtask

  task automatic send_line(input int y);
    send_range(0, LW - 1, y);
  endtask

  task automatic release_pulse();
    @(negedge clk);
    line_release = 1'b1;
    @(negedge clk);
    line_release = 1'b0;
  endtask

  task automatic read_chk(input string name, input int addr, input logic [DW-1:0] exp);
    @(negedge clk);
    rd_addr = 10'(addr);
    @(negedge clk);
    check(name, 32'(rd_data), 32'(exp));
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    nReset = 1'b0;
    #1;
    check({tag, "_rst_valid"}, 32'(line_valid), 0);
    check({tag, "_rst_line_y"}, 32'(line_y), 0);
    check({tag, "_rst_rd_data"}, 32'(rd_data), 0);
    check({tag, "_rst_overflow"}, 32'(overflow), 0);
    check({tag, "_rst_short"}, 32'(short_line), 0);
    check({tag, "_rst_drop"}, 32'(drop_count), 0);
    @(negedge clk);
    nReset = 1'b1;
  endtask

  initial begin
    vec[0] = '{addr: 10'd0,   exp: 24'h002800};
    vec[1] = '{addr: 10'd359, exp: 24'h002967};
    vec[2] = '{addr: 10'd719, exp: 24'h002ACF};

    nReset       = 1'b0;
    pixel_ce     = 1'b0;
    pixel_x      = '0;
    pixel_y      = '0;
    pixel_data   = '0;
    rd_addr      = '0;
    line_release = 1'b0;
    repeat (3) @(negedge clk);
    do_reset("init");

    // Single line y=10, valid exactly one edge after x=719.
    send_range(0, LW - 2, 10);
    check("single_valid_before_last", 32'(line_valid), 0);
    strobe(LW - 1, 10, 1'b0);
    check("single_valid", 32'(line_valid), 1);
    check("single_line_y", 32'(line_y), 10);
    for (int i = 0; i < 3; i++) read_chk("single_rd", int'(vec[i].addr), vec[i].exp);
    release_pulse();
    check("single_released", 32'(line_valid), 0);
    release_pulse();
    check("idle_release_valid", 32'(line_valid), 0);

    // Ping-pong plus release coinciding with x=0 of a third line into the released bank.
    send_line(0);
    check("pp_valid0", 32'(line_valid), 1);
    check("pp_line_y0", 32'(line_y), 0);
    send_line(2);
    check("pp_line_y_oldest", 32'(line_y), 0);
    read_chk("pp_rd_y0", 359, pix(0, 359));
    strobe(0, 4, 1'b1);
    check("edge_overflow", 32'(overflow), 0);
    check("edge_drop", 32'(drop_count), 0);
    check("edge_line_y", 32'(line_y), 2);
    send_range(1, LW - 1, 4);
    check("edge_valid", 32'(line_valid), 1);
    read_chk("edge_rd_y2", 359, pix(2, 359));
    release_pulse();
    check("pp_hold_valid", 32'(line_valid), 1);
    check("pp_hold_line_y", 32'(line_y), 4);
    read_chk("edge_rd_y4_0", 0, pix(4, 0));
    read_chk("edge_rd_y4_719", 719, pix(4, 719));
    release_pulse();
    check("pp_final_valid", 32'(line_valid), 0);
    check("pp_final_overflow", 32'(overflow), 0);

    // Overflow: third line dropped whole, fourth line after a release is captured.
    send_line(0);
    send_line(2);
    send_line(4);
    check("ovf_flag", 32'(overflow), 1);
    check("ovf_drop", 32'(drop_count), 1);
    check("ovf_valid", 32'(line_valid), 1);
    check("ovf_line_y", 32'(line_y), 0);
    read_chk("ovf_rd_y0", 719, pix(0, 719));
    release_pulse();
    check("ovf_rel_valid", 32'(line_valid), 1);
    check("ovf_rel_line_y", 32'(line_y), 2);
    read_chk("ovf_rd_y2", 100, pix(2, 100));
    send_line(6);
    check("ovf_drop_after", 32'(drop_count), 1);
    check("ovf_line_y_kept", 32'(line_y), 2);
    release_pulse();
    check("ovf_line_y6", 32'(line_y), 6);
    read_chk("ovf_rd_y6", 500, pix(6, 500));
    release_pulse();
    check("ovf_empty", 32'(line_valid), 0);

    // Short line: restart mid-line reuses the same bank.
    do_reset("short");
    send_range(0, 99, 3);
    send_line(5);
    check("short_flag", 32'(short_line), 1);
    check("short_drop", 32'(drop_count), 0);
    check("short_overflow", 32'(overflow), 0);
    check("short_valid", 32'(line_valid), 1);
    check("short_line_y", 32'(line_y), 5);
    read_chk("short_rd50", 50, pix(5, 50));
    read_chk("short_rd600", 600, pix(5, 600));
    release_pulse();
    check("short_one_line", 32'(line_valid), 0);

    // Reset mid-line: remainder of the line is ignored until the next x=0.
    send_range(0, 300, 7);
    do_reset("mid");
    send_range(301, LW - 1, 7);
    check("mid_valid", 32'(line_valid), 0);
    check("mid_line_y", 32'(line_y), 0);
    check("mid_short", 32'(short_line), 0);
    check("mid_drop", 32'(drop_count), 0);
    send_line(9);
    check("mid_next_valid", 32'(line_valid), 1);
    check("mid_next_line_y", 32'(line_y), 9);
    read_chk("mid_rd", 359, pix(9, 359));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
